dsp_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the `dsp` downconverter/CORDIC block. It drives `dds_ftw` and `decimation` into `dsp` and steps the LO through `n_steps` frequencies. At each point it discards a programmable number of settling results, captures one set of magnitude/phase values, and presents it on a valid/ready result port. It sits between the CSR/host sequencing logic and `dsp`; results go to a FIFO or DMA writer.

---
 rtl/dsp_sweep_pkg.sv | 16 +
 rtl/sweep_result_latch.sv | 60 ++++++
 rtl/dsp_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dsp_sweep_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sweep_pkg.sv
// Shared widths and state encoding for the dsp frequency-sweep scheduler.
package dsp_sweep_pkg;

  localparam int unsigned FTW_W    = 32;
  localparam int unsigned IDX_W    = 12;
  localparam int unsigned DEC_W    = 13;
  localparam int unsigned SETTLE_W = 4;

  // Sweep FSM encoding kept as plain constants for compatibility with older tools.
  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StSettle  = 2'd1;
  localparam state_t StCapture = 2'd2;
  localparam state_t StHold    = 2'd3;

endpackage

// File: rtl/sweep_result_latch.sv
// Result register bank: one snapshot of the dsp magnitude/phase channels plus
// the point index and tuning word it was taken at.
module sweep_result_latch
  import dsp_sweep_pkg::*;
#(
  parameter int unsigned W_CORDIC = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [IDX_W-1:0]           index_in,
  input  logic [FTW_W-1:0]           ftw_in,
  input  logic [W_CORDIC-1:0]        mag_ref_in,
  input  logic [W_CORDIC-1:0]        mag_a_in,
  input  logic [W_CORDIC-1:0]        mag_b_in,
  input  logic [W_CORDIC-1:0]        mag_c_in,
  input  logic signed [W_CORDIC:0]   phase_ref_in,
  input  logic signed [W_CORDIC:0]   phase_a_in,
  input  logic signed [W_CORDIC:0]   phase_b_in,
  input  logic signed [W_CORDIC:0]   phase_c_in,
  output logic [IDX_W-1:0]           index_out,
  output logic [FTW_W-1:0]           ftw_out,
  output logic [W_CORDIC-1:0]        mag_ref_out,
  output logic [W_CORDIC-1:0]        mag_a_out,
  output logic [W_CORDIC-1:0]        mag_b_out,
  output logic [W_CORDIC-1:0]        mag_c_out,
  output logic signed [W_CORDIC:0]   phase_ref_out,
  output logic signed [W_CORDIC:0]   phase_a_out,
  output logic signed [W_CORDIC:0]   phase_b_out,
  output logic signed [W_CORDIC:0]   phase_c_out
);

  // Capture all channels together on load; hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_out     <= '0;
      ftw_out       <= '0;
      mag_ref_out   <= '0;
      mag_a_out     <= '0;
      mag_b_out     <= '0;
      mag_c_out     <= '0;
      phase_ref_out <= '0;
      phase_a_out   <= '0;
      phase_b_out   <= '0;
      phase_c_out   <= '0;
    end else if (load) begin
      index_out     <= index_in;
      ftw_out       <= ftw_in;
      mag_ref_out   <= mag_ref_in;
      mag_a_out     <= mag_a_in;
      mag_b_out     <= mag_b_in;
      mag_c_out     <= mag_c_in;
      phase_ref_out <= phase_ref_in;
      phase_a_out   <= phase_a_in;
      phase_b_out   <= phase_b_in;
      phase_c_out   <= phase_c_in;
    end
  end

endmodule

// File: rtl/dsp_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the dsp LO through n_steps tuning words,
// discards settle results after each retune, and hands one captured result
// per point to the downstream consumer over a valid/ready port.
module dsp_sweep_ctrl
  import dsp_sweep_pkg::*;
#(
  parameter int unsigned      W_CORDIC    = 31,
  parameter logic [DEC_W-1:0] DEC_DEFAULT = 13'd1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [FTW_W-1:0]         ftw_start,
  input  logic [FTW_W-1:0]         ftw_step,
  input  logic [IDX_W-1:0]         n_steps,
  input  logic [SETTLE_W-1:0]      settle,
  input  logic [DEC_W-1:0]         decimation_in,
  output logic [FTW_W-1:0]         dds_ftw,
  output logic [DEC_W-1:0]         decimation,
  input  logic                     dsp_strobe,
  input  logic [W_CORDIC-1:0]      dsp_mag_ref,
  input  logic [W_CORDIC-1:0]      dsp_mag_a,
  input  logic [W_CORDIC-1:0]      dsp_mag_b,
  input  logic [W_CORDIC-1:0]      dsp_mag_c,
  input  logic signed [W_CORDIC:0] dsp_phase_ref,
  input  logic signed [W_CORDIC:0] dsp_phase_a,
  input  logic signed [W_CORDIC:0] dsp_phase_b,
  input  logic signed [W_CORDIC:0] dsp_phase_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDX_W-1:0]         res_index,
  output logic [FTW_W-1:0]         res_ftw,
  output logic [W_CORDIC-1:0]      res_mag_ref,
  output logic [W_CORDIC-1:0]      res_mag_a,
  output logic [W_CORDIC-1:0]      res_mag_b,
  output logic [W_CORDIC-1:0]      res_mag_c,
  output logic signed [W_CORDIC:0] res_phase_ref,
  output logic signed [W_CORDIC:0] res_phase_a,
  output logic signed [W_CORDIC:0] res_phase_b,
  output logic signed [W_CORDIC:0] res_phase_c,
  output logic                     busy,
  output logic                     done
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [FTW_W-1:0]    ftw_q, ftw_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic                res_valid_q, res_valid_d;
  logic                done_q, done_d;
  logic                load;

  // Next-state logic; stop overrides everything, including a same-cycle strobe.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    ftw_d        = ftw_q;
    dec_d        = dec_q;
    res_valid_d  = res_valid_q;
    done_d       = 1'b0;
    load         = 1'b0;
    if (stop) begin
      state_d     = StIdle;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (n_steps != '0)) begin
            ftw_d        = ftw_start;
            dec_d        = decimation_in;
            idx_d        = '0;
            settle_cnt_d = settle;
            state_d      = (settle == '0) ? StCapture : StSettle;
          end
        end
        StSettle: begin
          if (dsp_strobe) begin
            settle_cnt_d = settle_cnt_q - 1'b1;
            if (settle_cnt_q <= SETTLE_W'(1)) state_d = StCapture;
          end
        end
        StCapture: begin
          if (dsp_strobe) begin
            load        = 1'b1;
            res_valid_d = 1'b1;
            state_d     = StHold;
          end
        end
        StHold: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            if (idx_q == n_steps - 1'b1) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d        = idx_q + 1'b1;
              ftw_d        = ftw_q + ftw_step;
              settle_cnt_d = settle;
              state_d      = (settle == '0) ? StCapture : StSettle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sweep state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      ftw_q        <= '0;
      dec_q        <= DEC_DEFAULT;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      ftw_q        <= ftw_d;
      dec_q        <= dec_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

  assign dds_ftw    = ftw_q;
  assign decimation = dec_q;
  assign res_valid  = res_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);

  sweep_result_latch #(
    .W_CORDIC (W_CORDIC)
  ) u_latch (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .index_in      (idx_q),
    .ftw_in        (ftw_q),
    .mag_ref_in    (dsp_mag_ref),
    .mag_a_in      (dsp_mag_a),
    .mag_b_in      (dsp_mag_b),
    .mag_c_in      (dsp_mag_c),
    .phase_ref_in  (dsp_phase_ref),
    .phase_a_in    (dsp_phase_a),
    .phase_b_in    (dsp_phase_b),
    .phase_c_in    (dsp_phase_c),
    .index_out     (res_index),
    .ftw_out       (res_ftw),
    .mag_ref_out   (res_mag_ref),
    .mag_a_out     (res_mag_a),
    .mag_b_out     (res_mag_b),
    .mag_c_out     (res_mag_c),
    .phase_ref_out (res_phase_ref),
    .phase_a_out   (res_phase_a),
    .phase_b_out   (res_phase_b),
    .phase_c_out   (res_phase_c)
  );

endmodule

// File: tb/tb_dsp_sweep_ctrl.sv
// Scoreboard bench for dsp_sweep_ctrl: directed sweeps push expected results,
// a monitor pops and compares on every accepted result.
module tb_dsp_sweep_ctrl;

  localparam int unsigned WC = 31;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   ftw_start = '0;
  logic [31:0]   ftw_step = '0;
  logic [11:0]   n_steps = '0;
  logic [3:0]    settle = '0;
  logic [12:0]   decimation_in = '0;
  logic [31:0]   dds_ftw;
  logic [12:0]   decimation;
  logic          dsp_strobe = 1'b0;
  logic [WC-1:0] dsp_mag_ref = '0, dsp_mag_a = '0, dsp_mag_b = '0, dsp_mag_c = '0;
  logic signed [WC:0] dsp_phase_ref = '0, dsp_phase_a = '0, dsp_phase_b = '0, dsp_phase_c = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [11:0]   res_index;
  logic [31:0]   res_ftw;
  logic [WC-1:0] res_mag_ref, res_mag_a, res_mag_b, res_mag_c;
  logic signed [WC:0] res_phase_ref, res_phase_a, res_phase_b, res_phase_c;
  logic          busy;
  logic          done;

  dsp_sweep_ctrl #(
    .W_CORDIC    (WC),
    .DEC_DEFAULT (13'd1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .ftw_start     (ftw_start),
    .ftw_step      (ftw_step),
    .n_steps       (n_steps),
    .settle        (settle),
    .decimation_in (decimation_in),
    .dds_ftw       (dds_ftw),
    .decimation    (decimation),
    .dsp_strobe    (dsp_strobe),
    .dsp_mag_ref   (dsp_mag_ref),
    .dsp_mag_a     (dsp_mag_a),
    .dsp_mag_b     (dsp_mag_b),
    .dsp_mag_c     (dsp_mag_c),
    .dsp_phase_ref (dsp_phase_ref),
    .dsp_phase_a   (dsp_phase_a),
    .dsp_phase_b   (dsp_phase_b),
    .dsp_phase_c   (dsp_phase_c),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_index     (res_index),
    .res_ftw       (res_ftw),
    .res_mag_ref   (res_mag_ref),
    .res_mag_a     (res_mag_a),
    .res_mag_b     (res_mag_b),
    .res_mag_c     (res_mag_c),
    .res_phase_ref (res_phase_ref),
    .res_phase_a   (res_phase_a),
    .res_phase_b   (res_phase_b),
    .res_phase_c   (res_phase_c),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] idx;
    logic [31:0] ftw;
    int          mag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // One dsp output strobe; the channel values are fixed offsets of mag.
  task automatic strobe(input int mag);
    dsp_strobe    = 1'b1;
    dsp_mag_ref   = WC'(mag);
    dsp_mag_a     = WC'(mag + 1);
    dsp_mag_b     = WC'(mag + 2);
    dsp_mag_c     = WC'(mag + 3);
    dsp_phase_ref = -(32'(mag) + 32'd4);
    dsp_phase_a   = -(32'(mag) + 32'd5);
    dsp_phase_b   = -(32'(mag) + 32'd6);
    dsp_phase_c   = -(32'(mag) + 32'd7);
    tick(1);
    dsp_strobe = 1'b0;
    tick(49);
  endtask

  task automatic push(input logic [11:0] idx, input logic [31:0] ftw, input int mag);
    exp_t e;
    e.idx = idx;
    e.ftw = ftw;
    e.mag = mag;
    sb.push_back(e);
  endtask

  // Monitor: compare every accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got index %0d ftw 0x%0h, expected none", res_index,
                 res_ftw);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_index", 64'(res_index), 64'(e.idx));
        chk("res_ftw", 64'(res_ftw), 64'(e.ftw));
        chk("res_mag_ref", 64'(res_mag_ref), 64'(WC'(e.mag)));
        chk("res_mag_c", 64'(res_mag_c), 64'(WC'(e.mag + 3)));
        chk("res_phase_a", 64'(32'(res_phase_a)), 64'(-(32'(e.mag) + 32'd5)));
        chk("res_phase_c", 64'(32'(res_phase_c)), 64'(-(32'(e.mag) + 32'd7)));
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    // Async reset between edges
    #2 reset = 1'b1;
    #1;
    chk("rst_dds_ftw", 64'(dds_ftw), 64'h0);
    chk("rst_decimation", 64'(decimation), 64'd1000);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_res_index", 64'(res_index), 64'h0);
    chk("rst_res_ftw", 64'(res_ftw), 64'h0);
    chk("rst_res_mag_ref", 64'(res_mag_ref), 64'h0);
    chk("rst_res_phase_c", 64'(32'(res_phase_c)), 64'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Basic sweep: settle=2, 3rd strobe after each retune is captured
    ftw_start = 32'h1000_0000; ftw_step = 32'h0100_0000; n_steps = 12'd3; settle = 4'd2;
    decimation_in = 13'd500; res_ready = 1'b1; done_cnt = 0;
    push(12'd0, 32'h1000_0000, 3);
    push(12'd1, 32'h1100_0000, 6);
    push(12'd2, 32'h1200_0000, 9);
    pulse_start();
    chk("basic_busy", 64'(busy), 64'h1);
    chk("basic_dds_ftw", 64'(dds_ftw), 64'h1000_0000);
    chk("basic_decimation", 64'(decimation), 64'd500);
    for (int m = 1; m <= 9; m++) strobe(m);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("basic_idle", 64'(busy), 64'h0);
    chk("basic_dds_ftw_kept", 64'(dds_ftw), 64'h1200_0000);

    // Zero settle: first strobe after each retune captured, two strobes total
    ftw_start = 32'h2000_0000; ftw_step = 32'h10; n_steps = 12'd2; settle = 4'd0; done_cnt = 0;
    push(12'd0, 32'h2000_0000, 20);
    push(12'd1, 32'h2000_0010, 21);
    pulse_start();
    strobe(20);
    strobe(21);
    chk("zero_idle_after_two", 64'(busy), 64'h0);
    strobe(22);
    chk("zero_extra_not_captured", 64'(res_mag_ref), 64'd21);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure in HOLD
    ftw_start = 32'h3000_0000; ftw_step = 32'h0100_0000; n_steps = 12'd2; settle = 4'd1;
    res_ready = 1'b0; done_cnt = 0;
    push(12'd0, 32'h3000_0000, 31);
    push(12'd1, 32'h3100_0000, 33);
    pulse_start();
    strobe(30);
    strobe(31);
    for (int i = 0; i < 10; i++) strobe(90 + i);
    chk("bp_valid_held", 64'(res_valid), 64'h1);
    chk("bp_mag_held", 64'(res_mag_ref), 64'd31);
    chk("bp_index_held", 64'(res_index), 64'd0);
    chk("bp_ftw_not_advanced", 64'(dds_ftw), 64'h3000_0000);
    res_ready = 1'b1;
    tick(1);
    chk("bp_valid_drop", 64'(res_valid), 64'h0);
    chk("bp_ftw_advanced", 64'(dds_ftw), 64'h3100_0000);
    strobe(32);
    strobe(33);
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);

    // Tuning-word wrap
    ftw_start = 32'hFFFF_FF00; ftw_step = 32'h200; n_steps = 12'd2; settle = 4'd0; done_cnt = 0;
    push(12'd0, 32'hFFFF_FF00, 40);
    push(12'd1, 32'h0000_0100, 41);
    pulse_start();
    strobe(40);
    strobe(41);
    chk("wrap_done_cnt", 64'(done_cnt), 64'd1);

    // Abort mid-SETTLE
    ftw_start = 32'h4000_0000; ftw_step = 32'h1; n_steps = 12'd2; settle = 4'd3; done_cnt = 0;
    pulse_start();
    strobe(50);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("abort_settle_busy", 64'(busy), 64'h0);
    chk("abort_settle_valid", 64'(res_valid), 64'h0);
    chk("abort_settle_ftw_kept", 64'(dds_ftw), 64'h4000_0000);
    strobe(51);
    strobe(52);
    strobe(53);
    chk("abort_settle_no_done", 64'(done_cnt), 64'd0);

    // Abort in HOLD with a pending result
    ftw_start = 32'h4800_0000; n_steps = 12'd3; settle = 4'd0; res_ready = 1'b0;
    pulse_start();
    strobe(60);
    chk("abort_hold_valid_before", 64'(res_valid), 64'h1);
    chk("abort_hold_mag", 64'(res_mag_ref), 64'd60);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("abort_hold_busy", 64'(busy), 64'h0);
    chk("abort_hold_valid", 64'(res_valid), 64'h0);
    chk("abort_hold_mag_kept", 64'(res_mag_ref), 64'd60);
    tick(5);
    chk("abort_hold_no_done", 64'(done_cnt), 64'd0);

    // Full sweep after abort
    ftw_start = 32'h5000_0000; ftw_step = 32'h1; n_steps = 12'd2; settle = 4'd1;
    res_ready = 1'b1; done_cnt = 0;
    push(12'd0, 32'h5000_0000, 71);
    push(12'd1, 32'h5000_0001, 73);
    pulse_start();
    for (int m = 70; m <= 73; m++) strobe(m);
    chk("restart_done_cnt", 64'(done_cnt), 64'd1);

    // start with n_steps == 0 is ignored
    n_steps = 12'd0; done_cnt = 0;
    pulse_start();
    chk("nzero_busy", 64'(busy), 64'h0);
    tick(5);
    chk("nzero_busy_later", 64'(busy), 64'h0);
    chk("nzero_no_done", 64'(done_cnt), 64'd0);

    // start while busy has no effect
    ftw_start = 32'h6000_0000; decimation_in = 13'd600; n_steps = 12'd1; settle = 4'd1;
    done_cnt = 0;
    push(12'd0, 32'h6000_0000, 81);
    pulse_start();
    tick(3);
    ftw_start = 32'h7000_0000; decimation_in = 13'd77;
    pulse_start();
    chk("busy_start_busy", 64'(busy), 64'h1);
    chk("busy_start_ftw", 64'(dds_ftw), 64'h6000_0000);
    chk("busy_start_dec", 64'(decimation), 64'd600);
    strobe(80);
    strobe(81);
    chk("busy_start_done_cnt", 64'(done_cnt), 64'd1);

    // Async reset mid-sweep, between edges
    ftw_start = 32'h7700_0000; decimation_in = 13'd321; n_steps = 12'd2; settle = 4'd2;
    pulse_start();
    strobe(85);
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_decimation", 64'(decimation), 64'd1000);
    chk("midrst_dds_ftw", 64'(dds_ftw), 64'h0);
    chk("midrst_res_index", 64'(res_index), 64'h0);
    chk("midrst_res_mag_ref", 64'(res_mag_ref), 64'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
